// File: rtl/cargo_stop_queue.sv
// Ordered stop list for the cargo elevator: each request inserts a pickup and a drop-off stop
// along the current travel path (carona), and arrivals at the head stop pop it.
module cargo_stop_queue #(
   parameter int FLOOR_W = 2,
   parameter int TYPE_W  = 2,
   parameter int ADDR_W  = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [FLOOR_W-1:0] req_origin,
   input  logic [FLOOR_W-1:0] req_dest,
   input  logic [TYPE_W-1:0]  req_type,
   output logic               req_error,
   output logic               insert_done,
   input  logic [FLOOR_W-1:0] current_floor,
   input  logic               arrive,
   output logic               head_valid,
   output logic [FLOOR_W-1:0] head_floor,
   output logic               head_is_origin,
   output logic [TYPE_W-1:0]  head_type,
   output logic               head_up,
   output logic               at_head,
   output logic [ADDR_W:0]    count,
   output logic               busy
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] C_MAXREQ = (ADDR_W+1)'(DEPTH - 2);
   localparam logic [ADDR_W:0] C_ONE    = (ADDR_W+1)'(1);

   typedef struct packed {
      logic               is_o;
      logic [TYPE_W-1:0]  typ;
      logic [FLOOR_W-1:0] fl;
   } entry_t;

   typedef enum logic [2:0] {S_IDLE, S_SCAN_O, S_INS_O, S_SCAN_D, S_INS_D} state_t;

   state_t             r_state, w_next;
   entry_t             r_q [DEPTH];
   logic [ADDR_W:0]    r_count, r_idx;
   logic [FLOOR_W-1:0] r_origin, r_dest;
   logic [TYPE_W-1:0]  r_type;
   logic               r_pop_pend, r_req_error, r_insert_done;

   logic [ADDR_W-1:0]  w_ip, w_im1;
   logic [FLOOR_W-1:0] w_prev, w_nfl;
   logic               w_at_head, w_accept, w_pop, w_end, w_up_req, w_seg_up;
   logic               w_fit_o, w_fit_d;
   entry_t             w_new;

   assign w_at_head = (r_count != '0) && (r_q[0].fl == current_floor);
   assign req_ready = (r_state == S_IDLE) && !r_pop_pend && !(arrive && w_at_head)
                      && (r_count <= C_MAXREQ);
   assign w_accept  = req_valid && req_ready;
   assign w_pop     = r_pop_pend || (arrive && w_at_head);

   // The segment (P,N] starts at the car itself for the first scan slot.
   assign w_ip     = r_idx[ADDR_W-1:0];
   assign w_im1    = w_ip - ADDR_W'(1);
   assign w_prev   = (r_idx == '0) ? current_floor : r_q[w_im1].fl;
   assign w_nfl    = r_q[w_ip].fl;
   assign w_end    = (r_idx == r_count);
   assign w_up_req = r_dest > r_origin;
   assign w_seg_up = w_nfl > w_prev;
   assign w_fit_o  = (w_prev != w_nfl) && (w_seg_up == w_up_req) &&
                     (w_up_req ? (r_origin > w_prev && r_origin <= w_nfl)
                               : (r_origin < w_prev && r_origin >= w_nfl));
   assign w_fit_d  = (w_prev != w_nfl) &&
                     (w_seg_up ? (r_dest > w_prev && r_dest <= w_nfl)
                               : (r_dest < w_prev && r_dest >= w_nfl));
   assign w_new    = '{is_o: (r_state == S_INS_O), typ: r_type,
                       fl: (r_state == S_INS_O) ? r_origin : r_dest};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (!w_pop && w_accept && (req_origin != req_dest)) w_next = S_SCAN_O;
         S_SCAN_O: if (w_end || w_fit_o) w_next = S_INS_O;
         S_INS_O:  w_next = S_SCAN_D;
         S_SCAN_D: if (w_end || w_fit_d) w_next = S_INS_D;
         S_INS_D:  w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned k = 0; k < DEPTH; k++) r_q[k] <= '0;
         r_count       <= '0;
         r_idx         <= '0;
         r_origin      <= '0;
         r_dest        <= '0;
         r_type        <= '0;
         r_pop_pend    <= 1'b0;
         r_req_error   <= 1'b0;
         r_insert_done <= 1'b0;
      end else begin
         r_req_error   <= 1'b0;
         r_insert_done <= 1'b0;
         if (r_state != S_IDLE && arrive && w_at_head) r_pop_pend <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  for (int unsigned k = 0; k < DEPTH - 1; k++) r_q[k] <= r_q[k+1];
                  r_q[DEPTH-1] <= '0;
                  r_count      <= r_count - C_ONE;
                  r_pop_pend   <= 1'b0;
               end else if (w_accept) begin
                  r_origin <= req_origin;
                  r_dest   <= req_dest;
                  r_type   <= req_type;
                  r_idx    <= '0;
                  if (req_origin == req_dest) r_req_error <= 1'b1;
               end
            end
            S_SCAN_O: if (!(w_end || w_fit_o)) r_idx <= r_idx + C_ONE;
            S_SCAN_D: if (!(w_end || w_fit_d)) r_idx <= r_idx + C_ONE;
            S_INS_O, S_INS_D: begin
               for (int unsigned k = 1; k < DEPTH; k++)
                  if (k > 32'(w_ip)) r_q[k] <= r_q[k-1];
               r_q[w_ip] <= w_new;
               r_count   <= r_count + C_ONE;
               r_idx     <= r_idx + C_ONE;
               if (r_state == S_INS_D) r_insert_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign req_error      = r_req_error;
   assign insert_done    = r_insert_done;
   assign count          = r_count;
   assign busy           = (r_state != S_IDLE);
   assign head_valid     = (r_count != '0);
   assign head_floor     = r_q[0].fl;
   assign head_is_origin = r_q[0].is_o;
   assign head_type      = r_q[0].typ;
   assign head_up        = r_q[0].fl > current_floor;
   assign at_head        = w_at_head;

endmodule

// File: tb/tb_cargo_stop_queue.sv
// Randomised bench for cargo_stop_queue: a queue-based stop-list model predicts placement,
// latency, head outputs and occupancy; directed cases cover full, deferred pop, error and reset.
module tb_cargo_stop_queue;

   localparam int FW    = 2;
   localparam int TW    = 2;
   localparam int AW    = 3;
   localparam int DEPTH = 2 ** AW;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [FW-1:0] req_origin = '0;
   logic [FW-1:0] req_dest = '0;
   logic [TW-1:0] req_type = '0;
   logic          req_error, insert_done;
   logic [FW-1:0] current_floor = '0;
   logic          arrive = 1'b0;
   logic          head_valid, head_is_origin, head_up, at_head, busy;
   logic [FW-1:0] head_floor;
   logic [TW-1:0] head_type;
   logic [AW:0]   count;

   cargo_stop_queue #(.FLOOR_W(FW), .TYPE_W(TW), .ADDR_W(AW)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_origin(req_origin), .req_dest(req_dest), .req_type(req_type),
      .req_error(req_error), .insert_done(insert_done),
      .current_floor(current_floor), .arrive(arrive),
      .head_valid(head_valid), .head_floor(head_floor), .head_is_origin(head_is_origin),
      .head_type(head_type), .head_up(head_up), .at_head(at_head),
      .count(count), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit is_o;
      int typ;
      int fl;
   } stop_t;

   stop_t mq[$];
   int    n_chk = 0;
   int    n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // First gap between consecutive stops (the car counting as the stop before index 0)
   // that contains fl; pickups additionally require the gap to run in the request direction.
   function automatic int find_slot(int fl, int start, int car, bit match_dir, bit up);
      int p, n;
      for (int i = start; i < mq.size(); i++) begin
         p = (i == 0) ? car : mq[i-1].fl;
         n = mq[i].fl;
         if (p != n && (!match_dir || ((n > p) == up))) begin
            if ((n > p) ? (fl > p && fl <= n) : (fl < p && fl >= n)) return i;
         end
      end
      return mq.size();
   endfunction

   function automatic int model_insert(int o, int d, int t, int car);
      int po, pd;
      po = find_slot(o, 0, car, 1'b1, d > o);
      mq.insert(po, '{1'b1, t, o});
      pd = find_slot(d, po + 1, car, 1'b0, 1'b0);
      mq.insert(pd, '{1'b0, t, d});
      return (po + 1) + 1 + (pd - po) + 1;
   endfunction

   task automatic chk_head(input string tag);
      int hf, ht;
      bit ho;
      hf = (mq.size() > 0) ? mq[0].fl : 0;
      ht = (mq.size() > 0) ? mq[0].typ : 0;
      ho = (mq.size() > 0) ? mq[0].is_o : 1'b0;
      chk({tag, ".count"}, count, mq.size());
      chk({tag, ".head_valid"}, head_valid, mq.size() != 0);
      chk({tag, ".head_floor"}, head_floor, hf);
      chk({tag, ".head_is_origin"}, head_is_origin, ho);
      chk({tag, ".head_type"}, head_type, ht);
      chk({tag, ".head_up"}, head_up, hf > int'(current_floor));
   endtask

   task automatic do_req(input int o, input int d, input int t);
      int  n0, lat, k;
      bit  exp_rdy;
      n0      = mq.size();
      exp_rdy = (n0 <= DEPTH - 2);
      req_origin = FW'(o);
      req_dest   = FW'(d);
      req_type   = TW'(t);
      req_valid  = 1'b1;
      #1;
      chk("req_ready", req_ready, exp_rdy);
      @(posedge clock); #1;
      req_valid = 1'b0;
      if (!exp_rdy) begin
         chk("refused.count", count, n0);
         chk("refused.busy", busy, 0);
         return;
      end
      if (o == d) begin
         chk("req_error", req_error, 1);
         chk("err.busy", busy, 0);
         chk("err.count", count, n0);
         @(posedge clock); #1;
         chk("err.pulse_end", req_error, 0);
         chk("err.no_done", insert_done, 0);
         return;
      end
      chk("accept.busy", busy, 1);
      chk("accept.no_err", req_error, 0);
      lat = model_insert(o, d, t, int'(current_floor));
      k = 0;
      do begin
         @(posedge clock); #1;
         k++;
      end while (!insert_done && k < 40);
      chk("latency", k, lat);
      chk("done.busy", busy, 0);
      @(posedge clock); #1;
      chk("done.pulse_end", insert_done, 0);
      chk_head("req");
   endtask

   task automatic do_arrive(input int f);
      bit exp;
      current_floor = FW'(f);
      #1;
      exp = (mq.size() > 0) && (mq[0].fl == f);
      chk("at_head", at_head, exp);
      arrive = 1'b1;
      @(posedge clock); #1;
      arrive = 1'b0;
      if (exp) void'(mq.pop_front());
      chk("arrive.busy", busy, 0);
      chk_head("arrive");
   endtask

   task automatic drain();
      while (mq.size() > 0) do_arrive(mq[0].fl);
   endtask

   initial begin
      int o, d, lat;
      #12;
      chk_head("reset");
      chk("reset.busy", busy, 0);
      chk("reset.insert_done", insert_done, 0);
      chk("reset.req_error", req_error, 0);
      reset = 1'b1;
      @(posedge clock); #1;

      // Basic request on an empty queue, car at floor 0.
      current_floor = '0;
      do_req(1, 3, 2);
      chk("t1.head_up", head_up, 1);
      chk("t1.count", count, 2);

      // Carona fit for both stops, then a downward request appended at the tail.
      drain();
      current_floor = '0;
      do_req(0, 3, 1);
      do_arrive(0);
      do_req(1, 2, 3);
      chk("t2.head_floor", head_floor, 1);
      do_req(2, 0, 1);
      drain();
      do_arrive(2);

      // Fill to capacity, then free slots one at a time.
      while (mq.size() <= DEPTH - 2) begin
         o = $urandom_range(0, 3);
         d = (o + $urandom_range(1, 3)) % 4;
         current_floor = FW'($urandom_range(0, 3));
         do_req(o, d, $urandom_range(0, 3));
      end
      chk("full.count", count, DEPTH);
      do_req(0, 1, 0);
      do_arrive(mq[0].fl);
      do_req(1, 0, 0);
      do_arrive(mq[0].fl);
      do_req(3, 1, 2);
      drain();

      // Arrival at head while in SCAN_D is deferred until after insert_done.
      current_floor = FW'(1);
      do_req(1, 3, 0);
      req_origin = FW'(2); req_dest = FW'(3); req_type = TW'(1);
      req_valid  = 1'b1;
      #1;
      chk("t4.ready", req_ready, 1);
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat = model_insert(2, 3, 1, 1);
      chk("t4.lat_model", lat, 5);
      repeat (3) @(posedge clock);
      #1;
      chk("t4.at_head", at_head, 1);
      arrive = 1'b1;
      @(posedge clock); #1;
      arrive = 1'b0;
      chk("t4.busy", busy, 1);
      @(posedge clock); #1;
      chk("t4.insert_done", insert_done, 1);
      chk("t4.count_pre", count, 4);
      chk("t4.ready_blocked", req_ready, 0);
      @(posedge clock); #1;
      void'(mq.pop_front());
      chk_head("t4");
      chk("t4.ready_after", req_ready, 1);
      drain();

      // Degenerate request and arrival on an empty queue.
      do_req(2, 2, 1);
      do_arrive(0);
      do_arrive(3);

      // Asynchronous reset in the middle of inserting the pickup.
      current_floor = '0;
      req_origin = FW'(1); req_dest = FW'(3); req_type = TW'(2);
      req_valid  = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      chk("t6.count", count, 0);
      chk("t6.head_valid", head_valid, 0);
      chk("t6.busy", busy, 0);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      chk("t6.no_done", insert_done, 0);
      chk("t6.count_after", count, 0);
      chk("t6.busy_after", busy, 0);

      // Random mix of requests and arrivals.
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 9) < 5) begin
            current_floor = FW'($urandom_range(0, 3));
            o = $urandom_range(0, 3);
            d = ($urandom_range(0, 7) == 0) ? o : (o + $urandom_range(1, 3)) % 4;
            do_req(o, d, $urandom_range(0, 3));
         end else if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
            do_arrive(mq[0].fl);
         end else begin
            do_arrive($urandom_range(0, 3));
         end
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
